spike_frame_decoder: RTL

SPIKE_FRAME_DECODER -- requirements
Module: spike_frame_decoder

---
 rtl/spike_frame_decoder.sv | 134 +++++++++++++
 1 files changed

// File: rtl/spike_frame_decoder.sv
// Spike frame decoder: counts spikes per slot, accumulates a signed
// per-frame balance over HEIGHT slots and emits a thresholded decision.
module spike_frame_decoder #(
  parameter int unsigned       WIDTH    = 8,
  parameter int unsigned       HEIGHT   = 7,
  parameter logic [HEIGHT-1:0] POS_MASK = HEIGHT'(7'b1110000),
  localparam int unsigned      CW       = WIDTH + 1,
  localparam int unsigned      IW       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int unsigned      BW       = $clog2(HEIGHT * (2 ** (WIDTH + 1))) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pixel_in,
  input  logic                 frame_in,
  output logic [CW-1:0]        count_out,
  output logic [IW-1:0]        slot_idx,
  output logic                 slot_valid,
  output logic signed [BW-1:0] balance_out,
  output logic                 neuron_out,
  output logic                 done
);

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [IW-1:0] IDX_LAST = IW'(HEIGHT - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic signed [BW-1:0] bal_q, bal_d;
  logic                 clr_q, clr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [IW-1:0]        slot_idx_q, slot_idx_d;
  logic                 valid_q, valid_d;
  logic                 neuron_q, neuron_d;
  logic                 done_q, done_d;

  logic                 close_c;
  logic                 spike_c;
  logic signed [BW-1:0] contrib_c;
  logic signed [BW-1:0] final_c;

  // Close event, qualified spike and the balance including the closing slot
  always_comb begin
    close_c   = (state_q == ACCUM) && !frame_in;
    spike_c   = frame_in && pixel_in;
    contrib_c = signed'(BW'(cnt_q));
    final_c   = POS_MASK[idx_q] ? (bal_q + contrib_c) : (bal_q - contrib_c);
  end

  // Next-state and datapath update; balance clears one cycle after frame end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    bal_d      = clr_q ? '0 : bal_q;
    clr_d      = 1'b0;
    count_d    = count_q;
    slot_idx_d = slot_idx_q;
    valid_d    = 1'b0;
    neuron_d   = neuron_q;
    done_d     = 1'b0;

    if (spike_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (frame_in) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (close_c) begin
          state_d    = IDLE;
          cnt_d      = '0;
          count_d    = cnt_q;
          slot_idx_d = idx_q;
          valid_d    = 1'b1;
          bal_d      = final_c;
          if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            neuron_d = !final_c[BW-1] && (final_c != '0);
            done_d   = 1'b1;
            clr_d    = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      bal_q      <= '0;
      clr_q      <= 1'b0;
      count_q    <= '0;
      slot_idx_q <= '0;
      valid_q    <= 1'b0;
      neuron_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      bal_q      <= bal_d;
      clr_q      <= clr_d;
      count_q    <= count_d;
      slot_idx_q <= slot_idx_d;
      valid_q    <= valid_d;
      neuron_q   <= neuron_d;
      done_q     <= done_d;
    end
  end

  assign count_out   = count_q;
  assign slot_idx    = slot_idx_q;
  assign slot_valid  = valid_q;
  assign balance_out = bal_q;
  assign neuron_out  = neuron_q;
  assign done        = done_q;

endmodule
